// File: rtl/orb_reader.sv
// orb_reader
//   Reads one frame of 12-bit orbital words from the shared packet RAM and
//   shifts each word out MSB-first on a bit line with a per-bit strobe.
//   Words are visited in packet order using the same address mapping the
//   packer writes with: addr = (word << 1) + (packet << 5).
//
// Parameters
//   BIT_DIV : clk cycles each output bit is held (2..255)
//   RD_LAT  : RAM read latency, RE/RdAddr to RdData valid (1..3)
//   WORDS   : words per frame (64 packets x 16 words)
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-low reset
//   req     in   frame request, asynchronous level; rising edge starts a frame
//   SW      in   packer buffer select, asynchronous
//   RdData  in   RAM read data
//   RdAddr  out  RAM read address (bit 0 always 0)
//   RE      out  RAM read enable, one-cycle pulse per word
//   RdBank  out  bank being read, ~SW captured at frame start
//   oBit    out  serial data, MSB first, 0 between words and when idle
//   bitStr  out  one-cycle pulse on the first clk of every bit
//   busy    out  high from frame start until the last bit ends
//   done    out  one-cycle pulse after the last bit of the frame
module orb_reader #(
    parameter int BIT_DIV = 4,
    parameter int RD_LAT  = 1,
    parameter int WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        SW,
    input  logic [11:0] RdData,
    output logic [10:0] RdAddr,
    output logic        RE,
    output logic        RdBank,
    output logic        oBit,
    output logic        bitStr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, SHIFT} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [9:0] W_LAST   = 10'(WORDS - 1);

    state_t      state;
    logic        req_p0, req_p1, req_p2;
    logic        sw_p0, sw_p1;
    logic        start;
    logic [9:0]  w;
    logic [9:0]  w_next;
    logic [3:0]  bcnt;
    logic [7:0]  div;
    logic [1:0]  lat;
    logic [10:0] shreg;   // bits still to be sent; bit 10 is the next one

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synced req
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_p0 <= 1'b0;
            req_p1 <= 1'b0;
            req_p2 <= 1'b0;
            sw_p0  <= 1'b0;
            sw_p1  <= 1'b0;
        end else begin
            req_p0 <= req;
            req_p1 <= req_p0;
            req_p2 <= req_p1;
            sw_p0  <= SW;
            sw_p1  <= sw_p0;
        end
    end

    assign start  = req_p1 & ~req_p2;
    assign w_next = w + 10'd1;

    // Control FSM; all outputs are registered so RE lines up with the READ
    // state and oBit/bitStr line up with the SHIFT state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            w      <= '0;
            bcnt   <= '0;
            div    <= '0;
            lat    <= '0;
            shreg  <= '0;
            RdAddr <= '0;
            RE     <= 1'b0;
            RdBank <= 1'b0;
            oBit   <= 1'b0;
            bitStr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            RE     <= 1'b0;
            bitStr <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // A start edge seen while busy never reaches here.
                    if (start) begin
                        RdBank <= ~sw_p1;
                        w      <= '0;
                        RdAddr <= '0;
                        RE     <= 1'b1;
                        busy   <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    lat   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Last WAIT cycle is RD_LAT cycles after RE: data valid now.
                    if (lat == LAT_LAST) begin
                        shreg  <= RdData[10:0];
                        oBit   <= RdData[11];
                        bitStr <= 1'b1;
                        div    <= '0;
                        bcnt   <= '0;
                        state  <= SHIFT;
                    end else begin
                        lat <= lat + 2'd1;
                    end
                end
                SHIFT: begin
                    if (div != DIV_LAST) begin
                        div <= div + 8'd1;
                    end else begin
                        div <= '0;
                        if (bcnt != 4'd11) begin
                            bcnt   <= bcnt + 4'd1;
                            oBit   <= shreg[10];
                            shreg  <= {shreg[9:0], 1'b0};
                            bitStr <= 1'b1;
                        end else begin
                            oBit <= 1'b0;
                            bcnt <= '0;
                            if (w == W_LAST) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                w      <= w_next;
                                RdAddr <= {w_next, 1'b0};
                                RE     <= 1'b1;
                                state  <= READ;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_orb_reader.sv
module tb_orb_reader;

    localparam int BIT_DIV = 4;
    localparam int RD_LAT  = 1;
    localparam int WORDS   = 1024;
    localparam int PERIOD  = 12 * BIT_DIV + 1 + RD_LAT;

    logic        clk;
    logic        rst;
    logic        req;
    logic        SW;
    logic [11:0] RdData;
    logic [10:0] RdAddr;
    logic        RE;
    logic        RdBank;
    logic        oBit;
    logic        bitStr;
    logic        busy;
    logic        done;

    orb_reader #(
        .BIT_DIV(BIT_DIV),
        .RD_LAT (RD_LAT),
        .WORDS  (WORDS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .SW    (SW),
        .RdData(RdData),
        .RdAddr(RdAddr),
        .RE    (RE),
        .RdBank(RdBank),
        .oBit  (oBit),
        .bitStr(bitStr),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet RAM: two banks, one-cycle read latency.
    logic [11:0] mem [2][2048];
    always @(posedge clk) begin
        if (RE) RdData <= mem[RdBank][RdAddr];
    end

    // Scoreboard state shared between driver and monitor.
    int          total = 0;
    int          bad   = 0;
    logic [10:0] exp_addr[$];
    bit          exp_bits[$];
    logic        exp_bank;
    int          exp_frames = 0;
    int          re_cnt   = 0;
    int          done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Reference: word k lives in packet k/16, slot k%16.
    task automatic push_frame(input logic bank);
        logic [11:0] wd;
        int          a;
        exp_bank = bank;
        for (int k = 0; k < WORDS; k++) begin
            a  = ((k % 16) * 2) + ((k / 16) * 32);
            exp_addr.push_back(11'(a));
            wd = mem[bank][a];
            for (int i = 0; i < 12; i++) exp_bits.push_back(wd[11 - i]);
        end
        exp_frames++;
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_bits.delete();
        exp_frames = 0;
    endtask

    task automatic wait_re(input int n, input int budget, input string nm);
        int i = 0;
        while (re_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 32'(re_cnt >= n), 1);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i  = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 32'(done_cnt != d0), 1);
    endtask

    function automatic logic [16:0] outs();
        return {RdAddr, RE, RdBank, oBit, bitStr, busy, done};
    endfunction

    // Monitor: pops expectations whenever the DUT presents RE or a bit.
    initial begin
        int  cyc = 0;
        int  first_re = 0;
        int  last_re = 0;
        int  last_str = 0;
        int  bit_idx = 0;
        int  hold_left = 0;
        bit  cur_bit = 1'b0;
        bit  e;
        bit  prev_busy = 1'b0;
        logic [10:0] a;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                re_cnt    = 0;
                bit_idx   = 0;
                hold_left = 0;
                prev_busy = 1'b0;
            end else begin
                if (RE) begin
                    if (exp_addr.size() == 0) begin
                        chk("re_unexpected", 32'(RdAddr), 32'hFFFF);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("re_addr", 32'(RdAddr), 32'(a));
                        chk("re_bank", 32'(RdBank), 32'(exp_bank));
                        chk("re_busy", 32'(busy), 1);
                    end
                    if (re_cnt == 0) first_re = cyc;
                    else chk("re_period", 32'(cyc - last_re), 32'(PERIOD));
                    last_re = cyc;
                    re_cnt++;
                end
                if (bitStr) begin
                    if (exp_bits.size() == 0) begin
                        chk("bit_unexpected", 32'(oBit), 32'hFFFF);
                        e = oBit;
                    end else begin
                        e = exp_bits.pop_front();
                        chk("bit_value", 32'(oBit), 32'(e));
                    end
                    if (bit_idx % 12 == 0) chk("first_bit_lat", 32'(cyc - last_re), 32'(1 + RD_LAT));
                    else                   chk("bit_spacing", 32'(cyc - last_str), 32'(BIT_DIV));
                    last_str  = cyc;
                    bit_idx++;
                    cur_bit   = e;
                    hold_left = BIT_DIV - 1;
                end else if (hold_left > 0) begin
                    chk("bit_hold", 32'(oBit), 32'(cur_bit));
                    hold_left--;
                end else begin
                    chk("gap_bit", 32'(oBit), 0);
                end
                if (done) begin
                    if (exp_frames == 0) begin
                        chk("done_unexpected", 32'(done), 0);
                    end else begin
                        exp_frames--;
                        chk("frame_len", 32'(cyc - first_re), 32'(WORDS * PERIOD));
                        chk("frame_words", 32'(re_cnt), 32'(WORDS));
                        chk("busy_at_done", 32'(busy), 0);
                        chk("busy_before_done", 32'(prev_busy), 1);
                    end
                    done_cnt++;
                    re_cnt  = 0;
                    bit_idx = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // Watchdog: the whole run is far shorter than this.
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle limit, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        int d0;
        rst = 1'b0;
        req = 1'b0;
        SW  = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 2048; a++)
                mem[b][a] = 12'($urandom);
        mem[1][0] = 12'hA5C;

        repeat (5) @(negedge clk);
        chk("reset_outs", 32'(outs()), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outs", 32'(outs()), 0);
        end

        // Frame 1: full address walk, bank latch, SW toggle, retrigger.
        push_frame(~SW);
        @(posedge clk);
        #2 req = 1'b1;
        wait_re(2, 200, "first_words");
        wait_re(300, 20000, "reach_word300");
        #2 SW = ~SW;
        wait_re(600, 20000, "reach_word600");
        @(posedge clk);
        #2 req = 1'b0;
        repeat ($urandom_range(3, 12)) @(posedge clk);
        #2 req = 1'b1;
        repeat ($urandom_range(3, 12)) @(posedge clk);
        #2 req = 1'b0;
        repeat ($urandom_range(3, 12)) @(posedge clk);
        #2 req = 1'b1;
        wait_done(52000, "frame1_done");
        chk("frame1_addr_left", 32'(exp_addr.size()), 0);
        chk("frame1_bits_left", 32'(exp_bits.size()), 0);
        repeat (3) @(negedge clk);
        chk("busy_after_frame1", 32'(busy), 0);

        // Frame 2: fresh rising edge, then reset at word 500.
        @(posedge clk);
        #2 req = 1'b0;
        repeat (10) @(posedge clk);
        push_frame(~SW);
        #2 req = 1'b1;
        wait_re(500, 30000, "reach_word500");
        #2 begin
            rst = 1'b0;
            req = 1'b0;
        end
        #1 chk("reset_midframe_outs", 32'(outs()), 0);
        flush();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        chk("idle_after_reset", 32'(outs()), 0);

        // Frame 3: random bank, restart from address 0, stop after a few words.
        SW = 1'($urandom);
        repeat (10) @(posedge clk);
        push_frame(~SW);
        #2 req = 1'b1;
        wait_re(8, 1000, "frame3_words");
        #2 begin
            rst = 1'b0;
            req = 1'b0;
        end
        #1 chk("reset_frame3_outs", 32'(outs()), 0);
        flush();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_idle", 32'(outs()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/orb_reader.md
Name: orb_reader

Overview:
- Read-side counterpart of the orbital-word packer.
- Reads one frame of 12-bit orbital words out of the shared packet RAM and serialises them MSB-first onto a bit line with a bit strobe.
- Sits between the packet RAM read port and the telemetry output shifter.
- A frame is 64 packets × 16 words, addressed as (word<<1)+(packet<<5), the same mapping the packer uses for writing.

Parameters:
- BIT_DIV, 4: clk cycles each output bit is held; legal range 2..255.
- RD_LAT, 1: RAM read latency in clk cycles, from RdAddr/RE to RdData valid; legal range 1..3.
- WORDS, 1024: words per frame (64 packets × 16 words).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  1  frame request from the telemetry master; asynchronous, level
- SW  in  1  buffer select driven by the packer side
- RdData  in  12  RAM read data
- RdAddr  out  11  RAM read address
- RE  out  1  RAM read enable, one-cycle pulse per word
- RdBank  out  1  bank being read = ~SW captured at frame start
- oBit  out  1  serial data, MSB first
- bitStr  out  1  one-cycle pulse on the first clk of every bit
- busy  out  1  high from frame start to the last bit end
- done  out  1  one-cycle pulse after the last bit of the frame

Behaviour:
- Input sync and start event
  - req and SW each pass through a 2-FF synchroniser.
  - Start event = rising edge of synced req (0→1 between consecutive cycles).
- Reset
  - All outputs are 0; state is IDLE.
  - Word counter, bit counter, divider and shift register are all 0.
  - Reset takes effect immediately when asserted, including mid-frame; no done pulse is produced.
- IDLE
  - On a start event: RdBank<=~SWsync, word counter w<=0, busy<=1, go to READ.
  - A start event while busy=1 is ignored. Only a fresh rising edge after the frame completes starts the next frame.
- Address generation
  - RdAddr = {w[9:4], w[3:0], 1'b0}, i.e. (w[3:0]<<1)+(w[9:4]<<5). Bit 0 is always 0.
  - Range is 0..2046.
- READ
  - RE=1 for exactly one cycle with RdAddr valid, then go to WAIT.
- WAIT
  - Hold for RD_LAT cycles, counting from the cycle after RE.
  - Then load shreg<=RdData and go to SHIFT.
- SHIFT
  - oBit=shreg[11]; bitStr=1 on the first cycle of each bit.
  - Each bit is held BIT_DIV cycles, then shreg shifts left.
  - After 12 bits:
    - if w==WORDS-1: done<=1 for one cycle, busy<=0, oBit<=0, go to IDLE;
    - otherwise: w<=w+1, go to READ.
  - Inter-word gap (READ + WAIT) = 1+RD_LAT cycles, during which oBit holds 0 and bitStr=0.
- SW handling
  - An SW toggle mid-frame does not change RdBank or w. The bank is latched only at frame start.
- Arithmetic and widths
  - w is 10 bits and does not wrap within a frame.
  - The bit counter is 4 bits (0..11).
  - The divider is 8 bits.
- req deasserted mid-frame: no effect; the frame completes.
- Frame duration = WORDS×(12×BIT_DIV + 1 + RD_LAT) cycles, measured from the first RE to the done pulse. With the defaults this is 51200.

Test Plan:
- Reset then idle: hold rst=0, then release with req=0 → all outputs 0, no RE, for 100 cycles.
- Single word: RAM model with RD_LAT=1, word 0 = 12'hA5C, start event.
  - First RE has RdAddr=0.
  - oBit sequence is 1,0,1,0,0,1,0,1,1,1,0,0, each bit 4 cycles, with bitStr pulses 4 cycles apart.
- Address walk: full frame.
  - RE addresses are 0,2,...,30,32,...,2046: 1024 pulses total.
  - done pulses exactly once, 51200 cycles after the first RE; busy falls on the same cycle.
- Bank latch: SW=0 at start event → RdBank=1. Toggle SW at word 300 → RdBank stays 1 and the address sequence is unbroken.
- Retrigger: pulse req 0→1→0→1 mid-frame → no restart and w continues. A new rising edge after done → second frame starts with RdAddr=0.
- Reset mid-frame: assert rst at word 500 → outputs 0 immediately, no done. After a new start event, RdAddr restarts at 0.
